// File: rtl/uc_pkg.sv
// uc_pkg: shared definitions for the multicycle RV32I control unit.
//   - RV32I base opcodes (OP_*)
//   - FSM state encoding (state_t, codes fixed for the debug port)
//   - register file write-data select codes (RF_*)
//   - one-hot instruction class (cls_t) produced by uc_opcode_decoder
package uc_pkg;

   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;

   typedef enum logic [2:0] {
      StIdle    = 3'd0,
      StFetch   = 3'd1,
      StDecode  = 3'd2,
      StExecute = 3'd3,
      StMem     = 3'd4,
      StWb      = 3'd5,
      StTrap    = 3'd6
   } state_t;

   localparam logic [1:0] RF_ALU = 2'b00;
   localparam logic [1:0] RF_MEM = 2'b01;
   localparam logic [1:0] RF_PC4 = 2'b10;
   localparam logic [1:0] RF_IMM = 2'b11;

   // At most one field set; all zero means the opcode is not RV32I base.
   typedef struct packed {
      logic r;
      logic imm;
      logic load;
      logic store;
      logic branch;
      logic jal;
      logic jalr;
      logic lui;
      logic auipc;
   } cls_t;

endpackage

// File: rtl/uc_opcode_decoder.sv
// uc_opcode_decoder: combinational opcode classifier.
//   i_opcode  in   7  IR[6:0]
//   o_cls     out     one-hot instruction class
//   o_legal   out  1  opcode belongs to the RV32I base set
module uc_opcode_decoder
   import uc_pkg::*;
(
   input  logic [6:0] i_opcode,
   output cls_t       o_cls,
   output logic       o_legal
);

   always_comb begin
      o_cls = '0;
      unique case (i_opcode)
         OP_R:      o_cls.r      = 1'b1;
         OP_IMM:    o_cls.imm    = 1'b1;
         OP_LOAD:   o_cls.load   = 1'b1;
         OP_STORE:  o_cls.store  = 1'b1;
         OP_BRANCH: o_cls.branch = 1'b1;
         OP_JAL:    o_cls.jal    = 1'b1;
         OP_JALR:   o_cls.jalr   = 1'b1;
         OP_LUI:    o_cls.lui    = 1'b1;
         OP_AUIPC:  o_cls.auipc  = 1'b1;
         default:   o_cls        = '0;
      endcase
   end

   assign o_legal = |o_cls;

endmodule

// File: rtl/uc_asm_mc.sv
// uc_asm_mc: multicycle RV32I control unit.
// Parameters: MEM_HANDSHAKE (1 = wait for mem_ready, 0 = fixed wait),
//             MEM_LATENCY (FETCH/MEM cycles in fixed mode, 1..15).
// Inputs : clk, reset (async, active low), opcode, branch_taken, mem_ready.
// Outputs: datapath enables/selects (WE_RF, WE_MEM, RF_din_sel, ULA_din1_sel,
//          ULA_din2_sel, load_pc, load_ir, pc_next_sel, pc_adder_sel, mem_req,
//          mem_addr_sel), sticky illegal trap flag and debug state code.
// Outputs are decoded combinationally from the registered state, so an
// asynchronous reset clears every enable (including mem_req) at once.
module uc_asm_mc
   import uc_pkg::*;
#(
   parameter int unsigned MEM_HANDSHAKE = 1,
   parameter int unsigned MEM_LATENCY   = 1
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [6:0] opcode,
   input  logic       branch_taken,
   input  logic       mem_ready,
   output logic       WE_RF,
   output logic       WE_MEM,
   output logic [1:0] RF_din_sel,
   output logic       ULA_din1_sel,
   output logic       ULA_din2_sel,
   output logic       load_pc,
   output logic       load_ir,
   output logic       pc_next_sel,
   output logic       pc_adder_sel,
   output logic       mem_req,
   output logic       mem_addr_sel,
   output logic       illegal,
   output logic [2:0] state
);

   localparam logic [3:0] LAT_LAST = 4'(MEM_LATENCY - 1);

   state_t     r_state;
   logic [3:0] r_cnt;
   logic       r_illegal;
   cls_t       w_cls;
   logic       w_legal;
   logic       w_mem_done;

   uc_opcode_decoder u_dec (
      .i_opcode (opcode),
      .o_cls    (w_cls),
      .o_legal  (w_legal)
   );

   // Completion of the current FETCH/MEM access; only meaningful in those states.
   assign w_mem_done = (MEM_HANDSHAKE != 0) ? mem_ready : (r_cnt == LAT_LAST);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state   <= StIdle;
         r_cnt     <= '0;
         r_illegal <= 1'b0;
      end else begin
         unique case (r_state)
            StIdle: r_state <= StFetch;
            StFetch, StMem: begin
               if (w_mem_done) begin
                  r_cnt <= '0;
                  if (r_state == StFetch) r_state <= StDecode;
                  else                    r_state <= w_cls.load ? StWb : StFetch;
               end else if (MEM_HANDSHAKE == 0) begin
                  r_cnt <= r_cnt + 4'd1;
               end
            end
            StDecode: begin
               if (w_legal) begin
                  r_state <= StExecute;
               end else begin
                  r_state   <= StTrap;
                  r_illegal <= 1'b1;
               end
            end
            StExecute: r_state <= (w_cls.load || w_cls.store) ? StMem : StFetch;
            StWb:      r_state <= StFetch;
            StTrap:    r_state <= StTrap;
            default:   r_state <= StIdle;
         endcase
      end
   end

   always_comb begin
      WE_RF        = 1'b0;
      WE_MEM       = 1'b0;
      RF_din_sel   = RF_ALU;
      ULA_din1_sel = 1'b0;
      ULA_din2_sel = 1'b0;
      load_pc      = 1'b0;
      load_ir      = 1'b0;
      pc_next_sel  = 1'b0;
      pc_adder_sel = 1'b0;
      mem_req      = 1'b0;
      mem_addr_sel = 1'b0;
      unique case (r_state)
         StFetch: begin
            mem_req = 1'b1;
            load_ir = w_mem_done;
         end
         StExecute: begin
            if (w_cls.r) begin
               WE_RF   = 1'b1;
               load_pc = 1'b1;
            end else if (w_cls.imm) begin
               ULA_din2_sel = 1'b1;
               WE_RF        = 1'b1;
               load_pc      = 1'b1;
            end else if (w_cls.lui) begin
               WE_RF      = 1'b1;
               RF_din_sel = RF_IMM;
               load_pc    = 1'b1;
            end else if (w_cls.auipc) begin
               ULA_din1_sel = 1'b1;
               ULA_din2_sel = 1'b1;
               WE_RF        = 1'b1;
               load_pc      = 1'b1;
            end else if (w_cls.jal) begin
               WE_RF        = 1'b1;
               RF_din_sel   = RF_PC4;
               pc_adder_sel = 1'b1;
               load_pc      = 1'b1;
            end else if (w_cls.jalr) begin
               ULA_din2_sel = 1'b1;
               WE_RF        = 1'b1;
               RF_din_sel   = RF_PC4;
               pc_next_sel  = 1'b1;
               load_pc      = 1'b1;
            end else if (w_cls.branch) begin
               pc_adder_sel = branch_taken;
               load_pc      = 1'b1;
            end else if (w_cls.load || w_cls.store) begin
               ULA_din2_sel = 1'b1;  // address = rs1 + imm
            end
         end
         StMem: begin
            mem_req      = 1'b1;
            mem_addr_sel = 1'b1;
            ULA_din2_sel = 1'b1;
            WE_MEM       = w_cls.store;
            load_pc      = w_cls.store & w_mem_done;  // loads retire in WB
         end
         StWb: begin
            WE_RF      = 1'b1;
            RF_din_sel = RF_MEM;
            load_pc    = 1'b1;
         end
         default: ;
      endcase
   end

   assign illegal = r_illegal;
   assign state   = r_state;

endmodule
